// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits resolved CHUNK bits per stage with registered carries.
// Define PIPELINED_ADDSUB_SAT_EN to saturate out_sum on signed overflow.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] sum_q;
    logic [STAGES-1:0]            carry_q;
    logic [STAGES-1:0]            sub_q;
    logic                         ovf_q;

    logic [STAGES-1:0]            adv;
    logic                         full_tail;
    logic [STAGES-1:0]            src_valid;
    logic [STAGES-1:0]            src_c;
    logic [STAGES-1:0]            src_sub;
    logic [STAGES-1:0][WIDTH-1:0] src_a;
    logic [STAGES-1:0][WIDTH-1:0] src_b;
    logic [STAGES-1:0][WIDTH-1:0] src_sum;
    logic [STAGES-1:0][WIDTH-1:0] sum_d;
    logic [STAGES-1:0]            carry_d;
    logic [CHUNK:0]               chunk_res;
    logic                         msb_cin;
    logic [WIDTH-1:0]             fin_sum;
    logic                         fin_cout;
    logic                         fin_ovf;
    logic                         unused_last;

    // Stage k may move when some stage from k to the output is empty, or the consumer takes the result.
    always_comb begin
        adv       = '0;
        full_tail = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_tail = full_tail & valid_q[k];
            adv[k]    = out_ready | ~full_tail;
        end
    end

    always_comb begin
        src_valid    = '0;
        src_c        = '0;
        src_sub      = '0;
        src_a        = '0;
        src_b        = '0;
        src_sum      = '0;
        src_valid[0] = in_valid;
        src_a[0]     = in_a;
        src_b[0]     = in_sub ? ~in_b : in_b;
        src_c[0]     = in_sub ^ in_cin;
        src_sub[0]   = in_sub;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_c[k]     = carry_q[k-1];
            src_sub[k]   = sub_q[k-1];
            src_sum[k]   = sum_q[k-1];
        end

        sum_d     = '0;
        carry_d   = '0;
        chunk_res = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk_res = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                      + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, src_c[k]};
            sum_d[k]                  = src_sum[k];
            sum_d[k][k*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
            carry_d[k]                = chunk_res[CHUNK];
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit rather than split out of the chunk adder.
    always_comb begin
        msb_cin  = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1] ^ sum_d[STAGES-1][WIDTH-1];
        fin_ovf  = carry_d[STAGES-1] ^ msb_cin;
        fin_cout = carry_d[STAGES-1] ^ src_sub[STAGES-1];
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (fin_ovf) begin
            fin_sum = src_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fin_sum = sum_d[STAGES-1];
        end
`else
        fin_sum = sum_d[STAGES-1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            sub_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= src_valid[k];
                    a_q[k]     <= src_a[k];
                    b_q[k]     <= src_b[k];
                    sub_q[k]   <= src_sub[k];
                    if (k == STAGES - 1) begin
                        sum_q[k]   <= src_valid[k] ? fin_sum : '0;
                        carry_q[k] <= src_valid[k] & fin_cout;
                    end else begin
                        sum_q[k]   <= sum_d[k];
                        carry_q[k] <= carry_d[k];
                    end
                end
            end
            if (adv[STAGES-1]) begin
                ovf_q <= src_valid[STAGES-1] & fin_ovf;
            end
        end
    end

    assign unused_last = ^{a_q[STAGES-1], b_q[STAGES-1], sub_q[STAGES-1]};

    assign in_ready  = adv[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = carry_q[STAGES-1];
    assign out_ovf   = ovf_q;

endmodule
